// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage driving a single-outstanding data-memory handshake with a wait timeout.
// Optional misaligned-access trap is compiled in when MEM_MISALIGN_CHECK_EN is defined.
package mem_stage_pkg;
   typedef struct packed {
      logic memread;
      logic memwrite;
      logic regwrite;
      logic memtoreg;
   } ctrl_t;
endpackage

module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  ctrl_t       ex_mem_ctrl,
   input  logic [31:0] ex_mem_alu_out,
   input  logic [31:0] ex_mem_rs2,
   input  logic [4:0]  ex_mem_rd,
   input  logic [2:0]  ex_mem_funct3,
   input  logic [31:0] ex_mem_pc_plus4,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        mem_stall,
   output ctrl_t       mem_wb_ctrl,
   output logic [31:0] mem_wb_alu_out,
   output logic [31:0] mem_wb_load_data,
   output logic [4:0]  mem_wb_rd,
   output logic [31:0] mem_wb_pc_plus4,
   output logic        mem_err
);

   localparam logic [7:0] MAX_WAIT_W = 8'(MAX_WAIT);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        mem_err_q, mem_err_d;
   ctrl_t       wb_ctrl_q, wb_ctrl_d;
   logic [31:0] wb_alu_q, wb_alu_d;
   logic [31:0] wb_load_q, wb_load_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_pc_q, wb_pc_d;

   logic        access, is_store, is_load, misaligned;
   logic        req, stall, bubble;
   logic [1:0]  lane;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [31:0] load_data;

   assign access   = ex_mem_ctrl.memread | ex_mem_ctrl.memwrite;
   assign is_store = ex_mem_ctrl.memwrite;
   assign is_load  = ex_mem_ctrl.memread & ~ex_mem_ctrl.memwrite;
   assign lane     = ex_mem_alu_out[1:0];

`ifdef MEM_MISALIGN_CHECK_EN
   always_comb begin
      misaligned = 1'b0;
      if (ex_mem_funct3 == 3'b010)
         misaligned = (lane != 2'b00);
      else if (ex_mem_funct3 == 3'b001 || (!is_store && ex_mem_funct3 == 3'b101))
         misaligned = lane[0];
   end
`else
   assign misaligned = 1'b0;
`endif

   // Store data is replicated across lanes so the byte enables alone pick the target bytes.
   always_comb begin
      st_be    = 4'b0000;
      st_wdata = ex_mem_rs2;
      case (ex_mem_funct3)
         3'b000: begin
            st_wdata = {4{ex_mem_rs2[7:0]}};
            case (lane)
               2'd0:    st_be = 4'b0001;
               2'd1:    st_be = 4'b0010;
               2'd2:    st_be = 4'b0100;
               default: st_be = 4'b1000;
            endcase
         end
         3'b001: begin
            st_wdata = {2{ex_mem_rs2[15:0]}};
            st_be    = lane[1] ? 4'b1100 : 4'b0011;
         end
         3'b010:  st_be = 4'b1111;
         default: st_be = 4'b0000;
      endcase
   end

   always_comb begin
      case (lane)
         2'd0:    lane_byte = dmem_rdata[7:0];
         2'd1:    lane_byte = dmem_rdata[15:8];
         2'd2:    lane_byte = dmem_rdata[23:16];
         default: lane_byte = dmem_rdata[31:24];
      endcase
      lane_half = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (ex_mem_funct3)
         3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
         3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
         3'b010:  load_data = dmem_rdata;
         3'b100:  load_data = {24'h0, lane_byte};
         3'b101:  load_data = {16'h0, lane_half};
         default: load_data = 32'h0;
      endcase
   end

   // Bus handshake FSM; timeout takes priority over a late ack since the request is already withdrawn.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_err_d = 1'b0;
      req       = 1'b0;
      stall     = 1'b0;
      bubble    = 1'b0;
      case (state_q)
         IDLE: begin
            if (access) begin
               if (misaligned) begin
                  mem_err_d = 1'b1;
                  bubble    = 1'b1;
               end else begin
                  req = 1'b1;
                  if (!dmem_ack) begin
                     stall   = 1'b1;
                     state_d = WAIT;
                     cnt_d   = 8'd0;
                  end
               end
            end
         end
         WAIT: begin
            if (cnt_q == MAX_WAIT_W) begin
               mem_err_d = 1'b1;
               bubble    = 1'b1;
               state_d   = IDLE;
               cnt_d     = 8'd0;
            end else begin
               req = 1'b1;
               if (dmem_ack) begin
                  state_d = IDLE;
               end else begin
                  stall = 1'b1;
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (!rst_n) begin
         req   = 1'b0;
         stall = 1'b0;
      end
   end

   always_comb begin
      wb_ctrl_d = '0;
      wb_alu_d  = 32'h0;
      wb_load_d = 32'h0;
      wb_rd_d   = 5'h0;
      wb_pc_d   = 32'h0;
      if (!stall && !bubble) begin
         wb_ctrl_d = ex_mem_ctrl;
         wb_alu_d  = ex_mem_alu_out;
         wb_load_d = is_load ? load_data : 32'h0;
         wb_rd_d   = ex_mem_rd;
         wb_pc_d   = ex_mem_pc_plus4;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= 8'd0;
         mem_err_q <= 1'b0;
         wb_ctrl_q <= '0;
         wb_alu_q  <= 32'h0;
         wb_load_q <= 32'h0;
         wb_rd_q   <= 5'h0;
         wb_pc_q   <= 32'h0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mem_err_q <= mem_err_d;
         wb_ctrl_q <= wb_ctrl_d;
         wb_alu_q  <= wb_alu_d;
         wb_load_q <= wb_load_d;
         wb_rd_q   <= wb_rd_d;
         wb_pc_q   <= wb_pc_d;
      end
   end

   assign dmem_req         = req;
   assign dmem_we          = req & is_store;
   assign dmem_addr        = req ? {ex_mem_alu_out[31:2], 2'b00} : 32'h0;
   assign dmem_wdata       = (req && is_store) ? st_wdata : 32'h0;
   assign dmem_be          = (req && is_store) ? st_be : 4'b0000;
   assign mem_stall        = stall;
   assign mem_err          = mem_err_q;
   assign mem_wb_ctrl      = wb_ctrl_q;
   assign mem_wb_alu_out   = wb_alu_q;
   assign mem_wb_load_data = wb_load_q;
   assign mem_wb_rd        = wb_rd_q;
   assign mem_wb_pc_plus4  = wb_pc_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage; expected MEM/WB results are queued when an instruction is driven.
// Misalignment expectations follow MEM_MISALIGN_CHECK_EN when it is defined for the build.
module tb_mem_stage;
   import mem_stage_pkg::*;

   localparam int MAX_WAIT = 4;
`ifdef MEM_MISALIGN_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   ctrl_t       ex_mem_ctrl;
   logic [31:0] ex_mem_alu_out, ex_mem_rs2, ex_mem_pc_plus4;
   logic [4:0]  ex_mem_rd;
   logic [2:0]  ex_mem_funct3;
   logic        dmem_req, dmem_we, dmem_ack, mem_stall, mem_err;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   ctrl_t       mem_wb_ctrl;
   logic [31:0] mem_wb_alu_out, mem_wb_load_data, mem_wb_pc_plus4;
   logic [4:0]  mem_wb_rd;

   typedef struct {
      logic        bubble;
      ctrl_t       ctrl;
      logic [31:0] alu;
      logic [31:0] load;
      logic [4:0]  rd;
      logic [31:0] pc;
   } exp_t;

   exp_t sbQ[$];
   int   checkCount = 0;
   int   errCount   = 0;

   mem_stage #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .ex_mem_ctrl      (ex_mem_ctrl),
      .ex_mem_alu_out   (ex_mem_alu_out),
      .ex_mem_rs2       (ex_mem_rs2),
      .ex_mem_rd        (ex_mem_rd),
      .ex_mem_funct3    (ex_mem_funct3),
      .ex_mem_pc_plus4  (ex_mem_pc_plus4),
      .dmem_req         (dmem_req),
      .dmem_we          (dmem_we),
      .dmem_addr        (dmem_addr),
      .dmem_wdata       (dmem_wdata),
      .dmem_be          (dmem_be),
      .dmem_ack         (dmem_ack),
      .dmem_rdata       (dmem_rdata),
      .mem_stall        (mem_stall),
      .mem_wb_ctrl      (mem_wb_ctrl),
      .mem_wb_alu_out   (mem_wb_alu_out),
      .mem_wb_load_data (mem_wb_load_data),
      .mem_wb_rd        (mem_wb_rd),
      .mem_wb_pc_plus4  (mem_wb_pc_plus4),
      .mem_err          (mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   function automatic ctrl_t mkCtrl(input logic rd, input logic wr, input logic rw, input logic m2r);
      ctrl_t c;
      c.memread  = rd;
      c.memwrite = wr;
      c.regwrite = rw;
      c.memtoreg = m2r;
      return c;
   endfunction

   function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
      logic [31:0] b, h;
      b = w >> (8 * a[1:0]);
      h = w >> (16 * a[1]);
      case (f3)
         3'b000:  return {{24{b[7]}}, b[7:0]};
         3'b001:  return {{16{h[15]}}, h[15:0]};
         3'b010:  return w;
         3'b100:  return b & 32'hFF;
         3'b101:  return h & 32'hFFFF;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [3:0] modelBe(input logic [2:0] f3, input logic [31:0] a);
      case (f3)
         3'b000:  return 4'b0001 << a[1:0];
         3'b001:  return 4'b0011 << (2 * a[1]);
         3'b010:  return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] d);
      case (f3)
         3'b000:  return {d[7:0], d[7:0], d[7:0], d[7:0]};
         3'b001:  return {d[15:0], d[15:0]};
         default: return d;
      endcase
   endfunction

   function automatic logic modelMisaligned(input logic [2:0] f3, input logic [31:0] a, input logic store);
      logic m;
      if (f3 == 3'b010)
         m = (a[1:0] != 2'b00);
      else if (f3 == 3'b001 || (!store && f3 == 3'b101))
         m = a[0];
      else
         m = 1'b0;
      return CHECK_EN && m;
   endfunction

   task automatic driveNop();
      ex_mem_ctrl     = '0;
      ex_mem_alu_out  = 32'h0;
      ex_mem_rs2      = 32'h0;
      ex_mem_rd       = 5'd0;
      ex_mem_funct3   = 3'b000;
      ex_mem_pc_plus4 = 32'h0;
      dmem_ack        = 1'b0;
      dmem_rdata      = 32'h0;
   endtask

   // Called just after a rising edge; ackDelay < 0 means the bus never answers.
   task automatic applyStimulus(input string tag, input ctrl_t c, input logic [31:0] addr,
                                input logic [31:0] rs2, input logic [2:0] f3, input logic [4:0] rd,
                                input int ackDelay, input logic [31:0] rdata);
      exp_t  e;
      exp_t  got;
      logic  access, store, mis, eReq, eStall, done;
      int    cycles, stalls, eStalls;
      ex_mem_ctrl     = c;
      ex_mem_alu_out  = addr;
      ex_mem_rs2      = rs2;
      ex_mem_funct3   = f3;
      ex_mem_rd       = rd;
      ex_mem_pc_plus4 = addr + 32'h1000;
      access = c.memread | c.memwrite;
      store  = c.memwrite;
      mis    = access && modelMisaligned(f3, addr, store);

      e.bubble = (access && mis) || (access && (ackDelay < 0 || ackDelay > MAX_WAIT));
      e.ctrl   = c;
      e.alu    = addr;
      e.load   = (c.memread && !c.memwrite) ? modelLoad(f3, addr, rdata) : 32'h0;
      e.rd     = rd;
      e.pc     = addr + 32'h1000;
      sbQ.push_back(e);

      if (!access || mis)                        eStalls = 0;
      else if (ackDelay >= 0 && ackDelay <= MAX_WAIT) eStalls = ackDelay;
      else                                       eStalls = MAX_WAIT + 1;

      cycles = 0;
      stalls = 0;
      done   = 1'b0;
      while (!done && cycles < 50) begin
         dmem_ack   = (ackDelay >= 0 && cycles == ackDelay);
         dmem_rdata = dmem_ack ? rdata : 32'hDEADBEEF;
         if (!access || mis) begin
            eReq = 1'b0; eStall = 1'b0; done = 1'b1;
         end else if (ackDelay >= 0 && ackDelay <= MAX_WAIT) begin
            eReq = 1'b1; eStall = (cycles < ackDelay); done = (cycles == ackDelay);
         end else begin
            eReq = (cycles <= MAX_WAIT); eStall = eReq; done = !eReq;
         end
         @(negedge clk);
         checkOutput({tag, "_req"}, {31'h0, dmem_req}, {31'h0, eReq});
         checkOutput({tag, "_stall"}, {31'h0, mem_stall}, {31'h0, eStall});
         if (mem_stall) stalls++;
         if (eReq) begin
            checkOutput({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
            checkOutput({tag, "_we"}, {31'h0, dmem_we}, {31'h0, store});
            if (store) begin
               checkOutput({tag, "_be"}, {28'h0, dmem_be}, {28'h0, modelBe(f3, addr)});
               checkOutput({tag, "_wdata"}, dmem_wdata, modelWdata(f3, rs2));
            end
         end else begin
            checkOutput({tag, "_we_idle"}, {31'h0, dmem_we}, 32'h0);
         end
         @(posedge clk);
         #1;
         cycles++;
      end
      if (!done) checkOutput({tag, "_cycle_bound"}, cycles, 32'hFFFFFFFF);
      dmem_ack = 1'b0;
      checkOutput({tag, "_stall_cycles"}, stalls, eStalls);

      got = sbQ.pop_front();
      checkOutput({tag, "_wb_ctrl"}, {28'h0, mem_wb_ctrl}, got.bubble ? 32'h0 : {28'h0, got.ctrl});
      checkOutput({tag, "_err"}, {31'h0, mem_err}, {31'h0, got.bubble});
      if (!got.bubble) begin
         checkOutput({tag, "_wb_alu"}, mem_wb_alu_out, got.alu);
         checkOutput({tag, "_wb_load"}, mem_wb_load_data, got.load);
         checkOutput({tag, "_wb_rd"}, {27'h0, mem_wb_rd}, {27'h0, got.rd});
         checkOutput({tag, "_wb_pc"}, mem_wb_pc_plus4, got.pc);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_req"}, {31'h0, dmem_req}, 32'h0);
      checkOutput({tag, "_stall"}, {31'h0, mem_stall}, 32'h0);
      checkOutput({tag, "_err"}, {31'h0, mem_err}, 32'h0);
      checkOutput({tag, "_wb_ctrl"}, {28'h0, mem_wb_ctrl}, 32'h0);
      checkOutput({tag, "_wb_alu"}, mem_wb_alu_out, 32'h0);
      checkOutput({tag, "_wb_load"}, mem_wb_load_data, 32'h0);
      checkOutput({tag, "_wb_rd"}, {27'h0, mem_wb_rd}, 32'h0);
      checkOutput({tag, "_wb_pc"}, mem_wb_pc_plus4, 32'h0);
   endtask

   initial begin
      ctrl_t ld, st, both, alu;
      ld   = mkCtrl(1'b1, 1'b0, 1'b1, 1'b1);
      st   = mkCtrl(1'b0, 1'b1, 1'b0, 1'b0);
      both = mkCtrl(1'b1, 1'b1, 1'b0, 1'b0);
      alu  = mkCtrl(1'b0, 1'b0, 1'b1, 1'b0);

      rst_n = 1'b0;
      driveNop();
      ex_mem_ctrl = ld;
      @(posedge clk);
      #1;
      checkAllZero("reset");
      driveNop();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      applyStimulus("sb_103",   st,   32'h103, 32'h000000AB, 3'b000, 5'd1, 0,  32'h0);
      applyStimulus("lb_102",   ld,   32'h102, 32'h0,        3'b000, 5'd2, 3,  32'h00800000);
      applyStimulus("lbu_102",  ld,   32'h102, 32'h0,        3'b100, 5'd3, 3,  32'h00800000);
      applyStimulus("lh_102",   ld,   32'h102, 32'h0,        3'b001, 5'd4, 1,  32'h80011234);
      applyStimulus("lhu_100",  ld,   32'h100, 32'h0,        3'b101, 5'd5, 0,  32'h8001F234);
      applyStimulus("lw_104",   ld,   32'h104, 32'h0,        3'b010, 5'd6, 2,  32'h12345678);
      applyStimulus("sh_102",   st,   32'h102, 32'h1234ABCD, 3'b001, 5'd7, 1,  32'h0);
      applyStimulus("sw_108",   st,   32'h108, 32'hCAFEF00D, 3'b010, 5'd8, 0,  32'h0);
      applyStimulus("rw_store", both, 32'h10C, 32'h55AA1234, 3'b010, 5'd9, 4,  32'h0);
      applyStimulus("nop_ack",  alu,  32'h777, 32'h0,        3'b010, 5'd10, 0, 32'hFFFFFFFF);
      applyStimulus("ld_f3_011", ld,  32'h110, 32'h0,        3'b011, 5'd11, 0, 32'h89ABCDEF);
      applyStimulus("sw_102",   st,   32'h102, 32'h11223344, 3'b010, 5'd12, 0, 32'h0);
      applyStimulus("lh_odd",   ld,   32'h101, 32'h0,        3'b001, 5'd13, 0, 32'hA5B6C7D8);
      applyStimulus("lw_tmo",   ld,   32'h200, 32'h0,        3'b010, 5'd14, -1, 32'h0);

      driveNop();
      @(posedge clk);
      #1;
      checkOutput("err_pulse_width", {31'h0, mem_err}, 32'h0);

      // Abandon an access mid-WAIT with an asynchronous reset.
      ex_mem_ctrl    = ld;
      ex_mem_alu_out = 32'h300;
      ex_mem_funct3  = 3'b010;
      ex_mem_rd      = 5'd15;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      checkOutput("wait_stall", {31'h0, mem_stall}, 32'h1);
      #3;
      rst_n = 1'b0;
      #1;
      checkAllZero("async_rst");
      driveNop();
      @(posedge clk);
      #1;
      checkAllZero("held_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("post_rst_err", {31'h0, mem_err}, 32'h0);
      applyStimulus("lw_after_rst", ld, 32'h304, 32'h0, 3'b010, 5'd16, 0, 32'h0BADC0DE);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: MAX_WAIT, 16, number of WAIT cycles without dmem_ack before the access is abandoned (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ex_mem_ctrl  input  ctrl_t  control bundle from EX/MEM; uses memread, memwrite, regwrite, memtoreg.
REQ-005 ex_mem_alu_out  input  32  effective address or ALU result.
REQ-006 ex_mem_rs2  input  32  forwarded store data.
REQ-007 ex_mem_rd, ex_mem_funct3, ex_mem_pc_plus4  input  5/3/32  passthrough destination, access size, link value.
REQ-008 dmem_req, dmem_we  output  1  bus request; write strobe (valid only with dmem_req).
REQ-009 dmem_addr  output  32  word-aligned address, {ex_mem_alu_out[31:2],2'b00}.
REQ-010 dmem_wdata, dmem_be  output  32/4  lane-aligned store data; byte enables.
REQ-011 dmem_ack, dmem_rdata  input  1/32  completion strobe; read word, valid in the dmem_ack cycle.
REQ-012 mem_stall  output  1  freeze request to the hazard unit; upstream holds EX/MEM stable while high.
REQ-013 mem_wb_ctrl, mem_wb_alu_out, mem_wb_load_data, mem_wb_rd, mem_wb_pc_plus4  output  ctrl_t/32/32/5/32  registered MEM/WB outputs.
REQ-014 mem_err  output  1  registered one-cycle pulse on abandoned or rejected access.

Function
REQ-015 An access exists when ex_mem_ctrl.memread or memwrite is 1; memread and memwrite both set is treated as a store.
REQ-016 FSM states IDLE and WAIT. In IDLE with an access, dmem_req SHALL be 1 combinationally in that cycle.
REQ-017 IDLE, access, dmem_ack=1 -> complete in that cycle, remain IDLE, mem_stall=0.
REQ-018 IDLE, access, dmem_ack=0 -> mem_stall=1, go to WAIT, wait counter cleared to 0.
REQ-019 WAIT: dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be held stable; mem_stall=1 until the ack cycle; counter increments each non-ack cycle.
REQ-020 WAIT, dmem_ack=1 -> complete, mem_stall=0 that cycle, back to IDLE.
REQ-021 WAIT, counter reaches MAX_WAIT without ack -> drop dmem_req, mem_stall=0, mem_err=1 next cycle, write a bubble to MEM/WB, back to IDLE.
REQ-022 A dmem_ack outside a request SHALL be ignored.
REQ-023 MEM/WB registers load every cycle with mem_stall=0; while mem_stall=1 they load a bubble (ctrl all zero, other fields don't-care).
REQ-024 Stores: funct3 000 SB (be=0001<<a[1:0], data byte replicated x4), 001 SH (be=0011<<{a[1],0}, half replicated x2), 010 SW (be=1111); other funct3 -> be=0000.
REQ-025 Loads select the lane by a[1:0]: 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU, 101 LHU zero-extend; other funct3 -> 0.
REQ-026 Non-access instructions pass through in one cycle with mem_wb_load_data=0 and no bus activity.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, counter 0, mem_err 0, all MEM/WB outputs 0 (ctrl all zero), dmem_req 0, mem_stall 0.
REQ-028 Reset during WAIT abandons the access with no mem_err pulse; after release the block accepts a new access in the first cycle.

Configuration
REQ-029 Macro MEM_MISALIGN_CHECK_EN defined: LH/LHU/SH with a[0]=1 or LW/SW with a[1:0]!=0 SHALL raise no dmem_req, no stall, mem_err=1 next cycle, bubble to MEM/WB.
REQ-030 Macro MEM_MISALIGN_CHECK_EN undefined: no check; halfword uses a[1] only, word ignores a[1:0]; mem_err raised only by timeout.

Verification
REQ-031 SB addr 0x103, rs2=0x000000AB, ack same cycle -> dmem_be=1000, dmem_wdata=0xABABABAB, mem_stall=0, dmem_we=1.
REQ-032 LB addr 0x102, rdata=0x00800000, ack after 3 cycles -> mem_stall high exactly 3 cycles, mem_wb_load_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-033 LW addr 0x200, no ack, MAX_WAIT=4 -> req dropped after 4 WAIT cycles, mem_err one pulse, mem_wb_ctrl.regwrite=0.
REQ-034 rst_n low mid-WAIT -> all outputs 0 asynchronously, no mem_err; next LW acks normally.
REQ-035 With MEM_MISALIGN_CHECK_EN, SW addr 0x102 -> dmem_req never asserted, mem_err pulse; without macro -> be=1111 to addr 0x100.
